ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline.
- Consumes the ID/EX register outputs and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Performs the ALU operation, branch condition and branch target computation.
- Registers the results into the EX/MEM pipeline register, which feeds the MEM stage.

---
 rtl/ex_stage_if.sv | 65 ++++++
 rtl/ex_stage.sv | 176 +++++++++++++++++
 tb/tb_ex_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX inputs, the MEM/WB forwarding inputs and the
// EX/MEM pipeline register outputs of the execute stage.
//   write / flush       : EX/MEM load enable and bubble insertion
//   *_in                : ID/EX register contents and MEM/WB bypass source
//   *_out               : registered EX/MEM results and control bits
// Modports:
//   slave  - the execute stage (consumes *_in, drives *_out)
//   master - whoever drives the stage (pipeline top or testbench)
interface ex_stage_if #(
   parameter int ADDR_W = 32
);
   logic              write;
   logic              flush;
   logic [ADDR_W-1:0] PC_in;
   logic [2:0]        funct3_in;
   logic [6:0]        funct7_in;
   logic [31:0]       ALU_A_in;
   logic [31:0]       ALU_B_in;
   logic [4:0]        RS1_in;
   logic [4:0]        RS2_in;
   logic [4:0]        RD_in;
   logic [31:0]       IMM_in;
   logic              RegWrite_WB_in;
   logic              MemtoReg_WB_in;
   logic              Branch_MEM_in;
   logic              MemRead_MEM_in;
   logic              MemWrite_MEM_in;
   logic [1:0]        ALUop_EX_in;
   logic              ALUSrc_in;
   logic [4:0]        WB_RD_in;
   logic              WB_RegWrite_in;
   logic [31:0]       WB_data_in;

   logic [ADDR_W-1:0] PC_branch_out;
   logic [31:0]       ALU_result_out;
   logic [31:0]       store_data_out;
   logic [4:0]        RD_out;
   logic [2:0]        funct3_out;
   logic              branch_cond_out;
   logic              RegWrite_WB_out;
   logic              MemtoReg_WB_out;
   logic              Branch_MEM_out;
   logic              MemRead_MEM_out;
   logic              MemWrite_MEM_out;

   modport slave (
      input  write, flush, PC_in, funct3_in, funct7_in, ALU_A_in, ALU_B_in,
             RS1_in, RS2_in, RD_in, IMM_in, RegWrite_WB_in, MemtoReg_WB_in,
             Branch_MEM_in, MemRead_MEM_in, MemWrite_MEM_in, ALUop_EX_in,
             ALUSrc_in, WB_RD_in, WB_RegWrite_in, WB_data_in,
      output PC_branch_out, ALU_result_out, store_data_out, RD_out,
             funct3_out, branch_cond_out, RegWrite_WB_out, MemtoReg_WB_out,
             Branch_MEM_out, MemRead_MEM_out, MemWrite_MEM_out
   );

   modport master (
      output write, flush, PC_in, funct3_in, funct7_in, ALU_A_in, ALU_B_in,
             RS1_in, RS2_in, RD_in, IMM_in, RegWrite_WB_in, MemtoReg_WB_in,
             Branch_MEM_in, MemRead_MEM_in, MemWrite_MEM_in, ALUop_EX_in,
             ALUSrc_in, WB_RD_in, WB_RegWrite_in, WB_data_in,
      input  PC_branch_out, ALU_result_out, store_data_out, RD_out,
             funct3_out, branch_cond_out, RegWrite_WB_out, MemtoReg_WB_out,
             Branch_MEM_out, MemRead_MEM_out, MemWrite_MEM_out
   );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage RV32I pipeline.
// Resolves operand forwarding (EX/MEM first, then MEM/WB), runs the ALU,
// evaluates the branch condition, computes PC+IMM and registers everything
// into the EX/MEM pipeline register.
// Ports:
//   clk - clock, all state on the rising edge
//   res - synchronous active-high reset, clears every output
//   bus - ex_stage_if.slave: ID/EX inputs, MEM/WB bypass, EX/MEM outputs
// Update priority on each edge: res > flush > write (write=0 holds).
module ex_stage #(
   parameter int FWD_EN = 1,
   parameter int ADDR_W = 32
) (
   input logic      clk,
   input logic      res,
   ex_stage_if.slave bus
);

   // EX/MEM pipeline register
   logic [ADDR_W-1:0] r_pc_branch;
   logic [31:0]       r_alu_result;
   logic [31:0]       r_store_data;
   logic [4:0]        r_rd;
   logic [2:0]        r_funct3;
   logic              r_branch_cond;
   logic              r_regwrite;
   logic              r_memtoreg;
   logic              r_branch;
   logic              r_memread;
   logic              r_memwrite;

   // Operand path
   logic [31:0]       w_src_val [2];
   logic [4:0]        w_src_idx [2];
   logic [31:0]       w_fwd     [2];
   logic [31:0]       w_op_a;
   logic [31:0]       w_op_b;
   logic [4:0]        w_shamt;
   logic              w_eq;
   logic              w_lt_s;
   logic              w_lt_u;
   logic [31:0]       w_alu_result;
   logic              w_cond;
   logic [ADDR_W-1:0] w_imm_ext;
   logic [ADDR_W-1:0] w_pc_branch;

   // Only funct7[5] selects SUB/SRA; the remaining bits carry no meaning here.
   logic              w_unused_f7;
   assign w_unused_f7 = &{1'b0, bus.funct7_in[6], bus.funct7_in[4:0]};

   assign w_src_val[0] = bus.ALU_A_in;
   assign w_src_val[1] = bus.ALU_B_in;
   assign w_src_idx[0] = bus.RS1_in;
   assign w_src_idx[1] = bus.RS2_in;

   // Per-operand bypass: the younger EX/MEM result wins over MEM/WB, and x0
   // is never bypassed because its architectural value is always zero.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         if (FWD_EN != 0) begin : g_on
            logic w_hit_exmem;
            logic w_hit_memwb;
            assign w_hit_exmem = r_regwrite && (r_rd != 5'd0) &&
                                 (r_rd == w_src_idx[gi]);
            assign w_hit_memwb = bus.WB_RegWrite_in && (bus.WB_RD_in != 5'd0) &&
                                 (bus.WB_RD_in == w_src_idx[gi]);
            assign w_fwd[gi] = w_hit_exmem ? r_alu_result :
                               w_hit_memwb ? bus.WB_data_in :
                                             w_src_val[gi];
         end else begin : g_off
            assign w_fwd[gi] = w_src_val[gi];
         end
      end
   endgenerate

   assign w_op_a  = w_fwd[0];
   // Store data always uses the forwarded rs2; the immediate only feeds the ALU.
   assign w_op_b  = bus.ALUSrc_in ? bus.IMM_in : w_fwd[1];
   assign w_shamt = w_op_b[4:0];
   assign w_eq    = (w_op_a == w_op_b);
   assign w_lt_s  = ($signed(w_op_a) < $signed(w_op_b));
   assign w_lt_u  = (w_op_a < w_op_b);

   always_comb begin
      w_alu_result = 32'd0;
      w_cond       = 1'b0;
      case (bus.ALUop_EX_in)
         2'b00: w_alu_result = w_op_a + w_op_b;
         2'b01: begin
            w_alu_result = w_op_a - w_op_b;
            case (bus.funct3_in)
               3'b000:  w_cond = w_eq;
               3'b001:  w_cond = !w_eq;
               3'b100:  w_cond = w_lt_s;
               3'b101:  w_cond = !w_lt_s;
               3'b110:  w_cond = w_lt_u;
               3'b111:  w_cond = !w_lt_u;
               default: w_cond = 1'b0;
            endcase
         end
         default: begin
            // 10 = R-type, 11 = I-type. I-type has no SUBI, so funct7[5]
            // only matters for ADD/SUB when the op class is R-type.
            case (bus.funct3_in)
               3'b000: w_alu_result = ((bus.ALUop_EX_in == 2'b10) && bus.funct7_in[5]) ?
                                      (w_op_a - w_op_b) : (w_op_a + w_op_b);
               3'b001: w_alu_result = w_op_a << w_shamt;
               3'b010: w_alu_result = {31'd0, w_lt_s};
               3'b011: w_alu_result = {31'd0, w_lt_u};
               3'b100: w_alu_result = w_op_a ^ w_op_b;
               3'b101: w_alu_result = bus.funct7_in[5] ?
                                      $unsigned($signed(w_op_a) >>> w_shamt) :
                                      (w_op_a >> w_shamt);
               3'b110: w_alu_result = w_op_a | w_op_b;
               default: w_alu_result = w_op_a & w_op_b;
            endcase
         end
      endcase
   end

   // Immediate is sign-extended to the PC width before the add so the target
   // wraps correctly for any ADDR_W.
   assign w_imm_ext   = ADDR_W'(signed'(bus.IMM_in));
   assign w_pc_branch = bus.PC_in + w_imm_ext;

   // Data half of EX/MEM: a flush still loads it, since a bubble's data is
   // never consumed once its controls are cleared.
   always_ff @(posedge clk) begin
      if (res) begin
         r_pc_branch  <= '0;
         r_alu_result <= 32'd0;
         r_store_data <= 32'd0;
         r_funct3     <= 3'd0;
      end else if (bus.flush || bus.write) begin
         r_pc_branch  <= w_pc_branch;
         r_alu_result <= w_alu_result;
         r_store_data <= w_fwd[1];
         r_funct3     <= bus.funct3_in;
      end
   end

   // Control half of EX/MEM: cleared by reset or flush, loaded on write.
   always_ff @(posedge clk) begin
      if (res || bus.flush) begin
         r_rd          <= 5'd0;
         r_branch_cond <= 1'b0;
         r_regwrite    <= 1'b0;
         r_memtoreg    <= 1'b0;
         r_branch      <= 1'b0;
         r_memread     <= 1'b0;
         r_memwrite    <= 1'b0;
      end else if (bus.write) begin
         r_rd          <= bus.RD_in;
         r_branch_cond <= w_cond & bus.Branch_MEM_in;
         r_regwrite    <= bus.RegWrite_WB_in;
         r_memtoreg    <= bus.MemtoReg_WB_in;
         r_branch      <= bus.Branch_MEM_in;
         r_memread     <= bus.MemRead_MEM_in;
         r_memwrite    <= bus.MemWrite_MEM_in;
      end
   end

   assign bus.PC_branch_out    = r_pc_branch;
   assign bus.ALU_result_out   = r_alu_result;
   assign bus.store_data_out   = r_store_data;
   assign bus.RD_out           = r_rd;
   assign bus.funct3_out       = r_funct3;
   assign bus.branch_cond_out  = r_branch_cond;
   assign bus.RegWrite_WB_out  = r_regwrite;
   assign bus.MemtoReg_WB_out  = r_memtoreg;
   assign bus.Branch_MEM_out   = r_branch;
   assign bus.MemRead_MEM_out  = r_memread;
   assign bus.MemWrite_MEM_out = r_memwrite;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed stimulus for ex_stage, checked every
// cycle against a behavioural EX/MEM model, plus literal expectations.
module tb_ex_stage;

   logic clk = 1'b0;
   logic res;
   always #5 clk = ~clk;

   ex_stage_if #(.ADDR_W(32)) bus ();

   ex_stage #(.FWD_EN(1), .ADDR_W(32)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] pcb;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        bc;
      logic        rw;
      logic        m2r;
      logic        br;
      logic        mrd;
      logic        mw;
   } exp_t;

   exp_t e;
   exp_t e_nxt;
   bit   dv;       // data fields meaningful (not after a flush)
   bit   dv_nxt;
   bit   chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Architectural bypass: most recent producer wins, x0 reads as its own value.
   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] raw);
      if (e.rw && e.rd != 5'd0 && e.rd == idx) return e.alu;
      if (bus.WB_RegWrite_in && bus.WB_RD_in != 5'd0 && bus.WB_RD_in == idx) return bus.WB_data_in;
      return raw;
   endfunction

   function automatic void alu_model(input logic [1:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic c);
      int sh;
      sh = int'(b[4:0]);
      c  = 1'b0;
      r  = 32'd0;
      if (op == 2'd0) begin
         r = a + b;
      end else if (op == 2'd1) begin
         r = a + (~b) + 32'd1;
         case (f3)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = ($signed(a) < $signed(b));
            3'd5: c = ($signed(a) >= $signed(b));
            3'd6: c = (a < b);
            3'd7: c = (a >= b);
            default: c = 1'b0;
         endcase
      end else begin
         case (f3)
            3'd0: r = (op == 2'd2 && f7[5]) ? a + (~b) + 32'd1 : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
               r = a >> sh;
               if (f7[5] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
   endfunction

   task automatic model_edge();
      logic [31:0] a, fb, b, r;
      logic        c;
      if (res) begin
         e_nxt  = '{default: '0};
         dv_nxt = 1'b1;
      end else if (bus.flush) begin
         e_nxt     = e;
         e_nxt.rd  = 5'd0;
         e_nxt.bc  = 1'b0;
         e_nxt.rw  = 1'b0;
         e_nxt.m2r = 1'b0;
         e_nxt.br  = 1'b0;
         e_nxt.mrd = 1'b0;
         e_nxt.mw  = 1'b0;
         dv_nxt    = 1'b0;
      end else if (bus.write) begin
         a  = fwd(bus.RS1_in, bus.ALU_A_in);
         fb = fwd(bus.RS2_in, bus.ALU_B_in);
         b  = bus.ALUSrc_in ? bus.IMM_in : fb;
         alu_model(bus.ALUop_EX_in, bus.funct3_in, bus.funct7_in, a, b, r, c);
         e_nxt.pcb = bus.PC_in + bus.IMM_in;
         e_nxt.alu = r;
         e_nxt.sd  = fb;
         e_nxt.rd  = bus.RD_in;
         e_nxt.f3  = bus.funct3_in;
         e_nxt.bc  = c & bus.Branch_MEM_in;
         e_nxt.rw  = bus.RegWrite_WB_in;
         e_nxt.m2r = bus.MemtoReg_WB_in;
         e_nxt.br  = bus.Branch_MEM_in;
         e_nxt.mrd = bus.MemRead_MEM_in;
         e_nxt.mw  = bus.MemWrite_MEM_in;
         dv_nxt    = 1'b1;
      end else begin
         e_nxt  = e;
         dv_nxt = dv;
      end
   endtask

   // Single compare process, well after the edge.
   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         cmp("RD_out",           32'(bus.RD_out),           32'(e.rd));
         cmp("branch_cond_out",  32'(bus.branch_cond_out),  32'(e.bc));
         cmp("RegWrite_WB_out",  32'(bus.RegWrite_WB_out),  32'(e.rw));
         cmp("MemtoReg_WB_out",  32'(bus.MemtoReg_WB_out),  32'(e.m2r));
         cmp("Branch_MEM_out",   32'(bus.Branch_MEM_out),   32'(e.br));
         cmp("MemRead_MEM_out",  32'(bus.MemRead_MEM_out),  32'(e.mrd));
         cmp("MemWrite_MEM_out", 32'(bus.MemWrite_MEM_out), 32'(e.mw));
         if (dv) begin
            cmp("PC_branch_out",  bus.PC_branch_out,       e.pcb);
            cmp("ALU_result_out", bus.ALU_result_out,      e.alu);
            cmp("store_data_out", bus.store_data_out,      e.sd);
            cmp("funct3_out",     32'(bus.funct3_out),     32'(e.f3));
         end
      end
   end

   task automatic step();
      model_edge();
      @(posedge clk);
      e  = e_nxt;
      dv = dv_nxt;
      #1;
   endtask

   task automatic clear_inputs();
      bus.write = 1'b1;            bus.flush = 1'b0;
      bus.PC_in = 32'd0;           bus.funct3_in = 3'd0;   bus.funct7_in = 7'd0;
      bus.ALU_A_in = 32'd0;        bus.ALU_B_in = 32'd0;
      bus.RS1_in = 5'd0;           bus.RS2_in = 5'd0;      bus.RD_in = 5'd0;
      bus.IMM_in = 32'd0;
      bus.RegWrite_WB_in = 1'b0;   bus.MemtoReg_WB_in = 1'b0;
      bus.Branch_MEM_in = 1'b0;    bus.MemRead_MEM_in = 1'b0;
      bus.MemWrite_MEM_in = 1'b0;  bus.ALUop_EX_in = 2'd0;  bus.ALUSrc_in = 1'b0;
      bus.WB_RD_in = 5'd0;         bus.WB_RegWrite_in = 1'b0;
      bus.WB_data_in = 32'd0;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 40));
         1:       return 32'h8000_0000 | 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_inputs();
      bus.write = ($urandom_range(0, 9) < 8);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.PC_in = $urandom;
      bus.funct3_in = 3'($urandom_range(0, 7));
      bus.funct7_in = ($urandom_range(0, 7) == 0) ? 7'($urandom) :
                      (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
      bus.ALU_A_in = rnd_val();
      bus.ALU_B_in = rnd_val();
      bus.RS1_in = 5'($urandom_range(0, 7));
      bus.RS2_in = 5'($urandom_range(0, 7));
      bus.RD_in  = 5'($urandom_range(0, 7));
      bus.IMM_in = rnd_val();
      bus.RegWrite_WB_in  = 1'($urandom);
      bus.MemtoReg_WB_in  = 1'($urandom);
      bus.Branch_MEM_in   = 1'($urandom);
      bus.MemRead_MEM_in  = 1'($urandom);
      bus.MemWrite_MEM_in = 1'($urandom);
      bus.ALUop_EX_in = 2'($urandom_range(0, 3));
      bus.ALUSrc_in   = 1'($urandom);
      bus.WB_RD_in    = 5'($urandom_range(0, 7));
      bus.WB_RegWrite_in = 1'($urandom);
      bus.WB_data_in  = rnd_val();
   endtask

   initial begin
      // Reset for two cycles under random inputs.
      res = 1'b1;
      rand_inputs();
      step();
      chk_en = 1'b1;
      rand_inputs();
      step();
      cmp("reset_alu", bus.ALU_result_out, 32'd0);
      cmp("reset_pcb", bus.PC_branch_out, 32'd0);
      cmp("reset_rw",  32'(bus.RegWrite_WB_out), 32'd0);

      // R-type SUB, first load after release.
      res = 1'b0;
      clear_inputs();
      bus.ALU_A_in = 32'd7; bus.ALU_B_in = 32'd5;
      bus.ALUop_EX_in = 2'b10; bus.funct7_in = 7'h20;
      step();
      cmp("rtype_sub", bus.ALU_result_out, 32'd2);

      // R-type SRA.
      clear_inputs();
      bus.ALU_A_in = 32'h8000_0000; bus.ALU_B_in = 32'd4;
      bus.ALUop_EX_in = 2'b10; bus.funct3_in = 3'b101; bus.funct7_in = 7'h20;
      step();
      cmp("rtype_sra", bus.ALU_result_out, 32'hF800_0000);

      // EX/MEM forwarding to rs1.
      clear_inputs();
      bus.ALU_A_in = 32'h10; bus.RD_in = 5'd3; bus.RegWrite_WB_in = 1'b1;
      step();
      cmp("fwd_setup", bus.ALU_result_out, 32'h10);
      clear_inputs();
      bus.RS1_in = 5'd3; bus.IMM_in = 32'd4; bus.ALUSrc_in = 1'b1;
      step();
      cmp("fwd_exmem", bus.ALU_result_out, 32'h14);

      // Same pattern targeting x0: no forwarding.
      clear_inputs();
      bus.ALU_A_in = 32'h10; bus.RD_in = 5'd0; bus.RegWrite_WB_in = 1'b1;
      step();
      clear_inputs();
      bus.RS1_in = 5'd0; bus.IMM_in = 32'd4; bus.ALUSrc_in = 1'b1;
      step();
      cmp("fwd_x0", bus.ALU_result_out, 32'd4);

      // EX/MEM (0xAA) beats MEM/WB (0xBB) for both operands.
      clear_inputs();
      bus.ALU_A_in = 32'hAA; bus.RD_in = 5'd5; bus.RegWrite_WB_in = 1'b1;
      step();
      clear_inputs();
      bus.RS1_in = 5'd5; bus.RS2_in = 5'd5; bus.ALUSrc_in = 1'b1;
      bus.WB_RD_in = 5'd5; bus.WB_RegWrite_in = 1'b1; bus.WB_data_in = 32'hBB;
      bus.MemWrite_MEM_in = 1'b1;
      step();
      cmp("prio_alu",   bus.ALU_result_out, 32'hAA);
      cmp("prio_store", bus.store_data_out, 32'hAA);

      // BLT taken, BLTU not taken with the same operands.
      clear_inputs();
      bus.PC_in = 32'h100; bus.IMM_in = 32'hFFFF_FFF8;
      bus.ALU_A_in = 32'hFFFF_FFFF; bus.ALU_B_in = 32'd1;
      bus.ALUop_EX_in = 2'b01; bus.funct3_in = 3'b100; bus.Branch_MEM_in = 1'b1;
      step();
      cmp("blt_cond", 32'(bus.branch_cond_out), 32'd1);
      cmp("blt_pcb",  bus.PC_branch_out, 32'hF8);
      bus.funct3_in = 3'b110; bus.RD_in = 5'd9; bus.RegWrite_WB_in = 1'b1;
      step();
      cmp("bltu_cond", 32'(bus.branch_cond_out), 32'd0);

      // Stall for three cycles: everything holds.
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         bus.write = 1'b0; bus.flush = 1'b0;
         step();
         cmp("stall_alu", bus.ALU_result_out, 32'hFFFF_FFFE);
         cmp("stall_pcb", bus.PC_branch_out, 32'hF8);
         cmp("stall_rd",  32'(bus.RD_out), 32'd9);
      end

      // Flush with write=0 still clears controls and rd.
      rand_inputs();
      bus.write = 1'b0; bus.flush = 1'b1;
      step();
      cmp("flush_rd", 32'(bus.RD_out), 32'd0);
      cmp("flush_rw", 32'(bus.RegWrite_WB_out), 32'd0);
      cmp("flush_br", 32'(bus.Branch_MEM_out), 32'd0);

      // Reset together with flush clears everything.
      rand_inputs();
      bus.write = 1'b1; bus.flush = 1'b0;
      step();
      rand_inputs();
      bus.flush = 1'b1;
      res = 1'b1;
      step();
      cmp("resflush_alu", bus.ALU_result_out, 32'd0);
      cmp("resflush_sd",  bus.store_data_out, 32'd0);
      cmp("resflush_pcb", bus.PC_branch_out, 32'd0);
      res = 1'b0;

      // Randomized run.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         res = ($urandom_range(0, 63) == 0);
         step();
      end

      chk_en = 1'b0;
      @(posedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
